gray_code_counter: RTL
======================

// Module: gray_code_counter
//
// PURPOSE
//   Upstream source for the binary-to-Gray conversion stage: a WIDTH-bit up/down
//   binary counter that presents each count together with its Gray encoding.
//   Uses a valid/ready handshake, so a consumer (encoder, pointer logic, display)
//   can apply backpressure. Supports load, wrap/saturate modes and terminal count.
//
// PARAMETERS
//   WIDTH  4  counter and code width in bits; modulus is 2**WIDTH
//   WRAP   1  1: wrap modulo 2**WIDTH; 0: saturate at the end value, then stop
//
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous, active-low reset
//   en         in   1      run enable: start from IDLE / continue after handshake
//   up         in   1      direction: 1 = increment, 0 = decrement
//   load       in   1      load load_val into the count (highest priority)
//   load_val   in   WIDTH  value for load
//   out_ready  in   1      consumer accepts the current code
//   out_valid  out  1      bin_out/gray_out hold a code to be consumed
//   bin_out    out  WIDTH  current binary count (registered)
//   gray_out   out  WIDTH  bin_out ^ (bin_out >> 1) (registered with bin_out)
//   tc         out  1      terminal count: out_valid && bin_out == (up ? all-ones : 0)
//
// BEHAVIOUR
//   - Reset (async assert, sync release): state=IDLE, bin_out=0, gray_out=0,
//     out_valid=0. tc=0 follows from out_valid=0. Reset mid-count clears
//     outputs immediately. No code is pending after release.
//   - Handshake hs = out_valid && out_ready. Outputs are stable while out_valid && !out_ready.
//   - FSM, states IDLE / VALID / DONE; out_valid = (state == VALID):
//       IDLE : en=1 -> VALID next cycle, presents current count unchanged.
//       VALID: hs && next count available -> count = count +/-1 (per up at hs);
//              stays VALID if en=1, else -> IDLE. Throughput: 1 code/cycle.
//              hs && WRAP=0 && bin_out at end value for up -> count held, -> DONE.
//       DONE : out_valid=0; en ignored; leaves only via load or reset.
//   - load=1 in any state: count=load_val, gray=encode(load_val), state=VALID
//     next cycle. An hs in the same cycle still counts as consumed, but load
//     overrides the advance.
//   - WRAP=1: 1111+1 -> 0000 and 0000-1 -> 1111 (WIDTH=4). The Gray output
//     changes exactly one bit per step, including across the wrap.
//   - Arithmetic is WIDTH bits unsigned; overflow is discarded (wrap) or
//     prevented (saturate).
//   - gray_out is registered from the next count, so it has zero latency
//     relative to bin_out.
//   - tc is combinational from the registered state and the up input.
//
// STRUCTURE
//   - Package gray_pkg: state enum (IDLE, VALID, DONE) and a WIDTH-generic
//     bin2gray function.
//   - Sub-module gray_encode #(WIDTH): purely combinational binary->Gray
//     encoder. It is instantiated on the next-count path.
//   - The top level holds the FSM, the count register and the output registers.
//
// TESTING  (WIDTH=4 unless stated)
//   1. rst_n low while VALID with bin=0111 -> bin/gray=0000/0000,
//      out_valid=0 without waiting for clk.
//   2. After reset: en=1, up=1, out_ready=1 -> first VALID 0000/0000, then
//      0001/0001, 0010/0011 ... 1111/1000 (tc=1), wrap to 0000/0000.
//      Check a 1-bit Gray change every step.
//   3. At 0101/0111 hold out_ready=0 for 3 cycles -> outputs stable, no
//      advance. Then out_ready=1 -> 0110/0101 on the next cycle.
//   4. load 0000, up=0, one hs -> 1111/1000. tc=1 at 0000 while up=0.
//   5. WRAP=0: load 1110, up=1 -> 1111/1000 with tc=1; hs -> DONE,
//      out_valid=0, en=1 ignored. Then load 0011 -> VALID 0011/0010.
//   6. At 0100 assert hs and load 1010 together -> next 1010/1111, not 0101.
//      Then en=0 with hs -> IDLE, count 1011.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code counter: FSM state encoding and
// a width-generic binary-to-Gray conversion.
package gray_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Widest code the helper supports; callers zero-extend and cast back down.
    localparam int unsigned GRAY_MAX_W = 32;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gray_encode.sv
// Purely combinational binary-to-Gray encoder, sized by WIDTH.
module gray_encode
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    // Zero-extension keeps the shifted-in MSB zero, so truncation is exact.
    assign gray = WIDTH'(bin2gray(GRAY_MAX_W'(bin)));

endmodule

// File: rtl/gray_code_counter.sv
// Up/down binary counter with registered Gray output and valid/ready handshake;
// supports load, wrap or saturate, and a terminal-count flag.
module gray_code_counter
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter bit          WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic [WIDTH-1:0] gray_reg,  gray_next;
    logic             hs;
    logic             at_end;

    assign hs     = (state_reg == VALID) && out_ready;
    assign at_end = up ? (count_reg == ALL_ONES) : (count_reg == ZERO);

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        if (load) begin
            // Load wins over any advance; a coincident handshake is simply consumed.
            state_next = VALID;
            count_next = load_val;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (en) begin
                        state_next = VALID;
                    end
                end
                VALID: begin
                    if (hs) begin
                        if (!WRAP && at_end) begin
                            state_next = DONE;
                        end else begin
                            count_next = up ? (count_reg + ONE) : (count_reg - ONE);
                            state_next = en ? VALID : IDLE;
                        end
                    end
                end
                DONE: begin
                    state_next = DONE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Encoding the next count lets gray_reg update in the same edge as count_reg.
    gray_encode #(
        .WIDTH (WIDTH)
    ) u_gray_encode (
        .bin  (count_next),
        .gray (gray_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            count_reg <= ZERO;
            gray_reg  <= ZERO;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            gray_reg  <= gray_next;
        end
    end

    assign out_valid = (state_reg == VALID);
    assign bin_out   = count_reg;
    assign gray_out  = gray_reg;
    assign tc        = out_valid && at_end;

endmodule
